// File: rtl/adpcm_encoder.sv
// Streaming 4-bit ADPCM encoder. It matches the sound-path ADPCM step decoder.
// It takes one signed 16-bit PCM sample per handshake. Each sample is turned into
// one nibble {sign, m[2:0]}, and two nibbles are packed into one byte. The encoder
// keeps its own copy of the decoder's predictor (step/sample) and updates it with
// the same arithmetic, so the decoder rebuilds the same sequence bit-exactly.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   io_start     synchronous predictor clear (highest priority)
//   io_in_*      PCM sample stream (valid/ready), io_in_bits is signed 16-bit
//   io_out_*     packed byte stream (valid/ready), earlier nibble in [7:4]
module adpcm_encoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_start,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [15:0] io_in_bits,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [7:0]  io_out_bits
);

  typedef enum logic [2:0] {StIdle, StS2, StS1, StS0, StUpd, StOut} state_e;

  localparam logic [16:0]        StepMin   = 17'd127;
  localparam logic [16:0]        StepMax   = 17'd24576;
  localparam logic signed [22:0] SampleMax = 23'sd32767;
  localparam logic signed [22:0] SampleMin = -23'sd32768;

  state_e             state_q, state_d;
  logic [16:0]        step_q, step_d;
  logic signed [16:0] sample_q, sample_d;
  logic [16:0]        mag_q, mag_d;
  logic               sign_q, sign_d;
  logic [2:0]         m_q, m_d;
  logic [3:0]         hi_q, hi_d;
  logic               half_q, half_d;
  logic [7:0]         out_q, out_d;

  // Sample acceptance: difference against the predicted sample
  logic [17:0] diff;
  logic [17:0] diff_abs;

  // Successive approximation of m = min(7, floor(4*mag/step))
  logic [2:0]  bit_sel;
  logic [2:0]  trial_m;
  logic [19:0] trial;
  logic [19:0] mag4;

  // Predictor update
  logic [3:0]         nibble;
  logic [3:0]         odd;
  logic [20:0]        step_odd;
  logic signed [21:0] sprod;
  logic signed [21:0] delta;
  logic signed [22:0] sum;
  logic [16:0]        sample_new;
  logic [9:0]         mul;
  logic [26:0]        step_mul;
  logic [18:0]        step_scaled;
  logic [16:0]        step_new;

  always_comb begin
    diff     = {{2{io_in_bits[15]}}, io_in_bits} - {sample_q[16], sample_q};
    diff_abs = diff[17] ? (~diff + 18'd1) : diff;

    unique case (state_q)
      StS2:    bit_sel = 3'b100;
      StS1:    bit_sel = 3'b010;
      default: bit_sel = 3'b001;
    endcase
    trial_m = m_q | bit_sel;
    trial   = 20'(step_q) * 20'(trial_m);
    mag4    = {1'b0, mag_q, 2'b00};
  end

  always_comb begin
    nibble   = {sign_q, m_q};
    odd      = {m_q, 1'b1};
    step_odd = 21'(step_q) * 21'(odd);
    sprod    = sign_q ? -$signed({1'b0, step_odd}) : $signed({1'b0, step_odd});
    // The arithmetic shift rounds toward -inf, which is how the decoder rounds.
    delta    = sprod >>> 3;
    sum      = $signed({{6{sample_q[16]}}, sample_q}) + $signed({delta[21], delta});
    if (sum > SampleMax) begin
      sample_new = 17'h07fff;
    end else if (sum < SampleMin) begin
      sample_new = 17'h18000;
    end else begin
      sample_new = sum[16:0];
    end

    case (m_q)
      3'd4:    mul = 10'd307;
      3'd5:    mul = 10'd409;
      3'd6:    mul = 10'd512;
      3'd7:    mul = 10'd614;
      default: mul = 10'd230;
    endcase
    step_mul    = 27'(step_q) * 27'(mul);
    step_scaled = 19'(step_mul >> 8);
    if (step_scaled > 19'(StepMax)) begin
      step_new = StepMax;
    end else if (step_scaled < 19'(StepMin)) begin
      step_new = StepMin;
    end else begin
      step_new = step_scaled[16:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    sample_d = sample_q;
    mag_d    = mag_q;
    sign_d   = sign_q;
    m_d      = m_q;
    hi_d     = hi_q;
    half_d   = half_q;
    out_d    = out_q;

    unique case (state_q)
      StIdle: begin
        if (io_in_valid) begin
          sign_d  = diff[17];
          mag_d   = diff_abs[16:0];
          m_d     = 3'd0;
          state_d = StS2;
        end
      end
      StS2, StS1, StS0: begin
        if (mag4 >= trial) begin
          m_d = trial_m;
        end
        unique case (state_q)
          StS2:    state_d = StS1;
          StS1:    state_d = StS0;
          default: state_d = StUpd;
        endcase
      end
      StUpd: begin
        sample_d = sample_new;
        step_d   = step_new;
        if (!half_q) begin
          hi_d    = nibble;
          half_d  = 1'b1;
          state_d = StIdle;
        end else begin
          out_d   = {hi_q, nibble};
          half_d  = 1'b0;
          state_d = StOut;
        end
      end
      StOut: begin
        if (io_out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // io_start overrides every state, including a half-built byte or a pending output.
    if (io_start) begin
      state_d  = StIdle;
      step_d   = StepMin;
      sample_d = '0;
      half_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      step_q   <= StepMin;
      sample_q <= '0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      half_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      sample_q <= sample_d;
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      half_q   <= half_d;
      out_q    <= out_d;
    end
  end

  // Held low during reset and during an io_start cycle, so a sample offered alongside
  // io_start is not taken.
  assign io_in_ready  = reset_n && !io_start && (state_q == StIdle);
  assign io_out_valid = (state_q == StOut);
  assign io_out_bits  = out_q;

endmodule

// File: tb/tb_adpcm_encoder.sv
// Self-checking bench for adpcm_encoder: a table of known pairs, hand-made
// sequences for latency/backpressure/io_start, and random PCM checked against a
// behavioural encoder model that uses plain integer arithmetic.
module tb_adpcm_encoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_start = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [15:0] io_in_bits = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [7:0]  io_out_bits;

  adpcm_encoder dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .io_start    (io_start),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_bits  (io_in_bits),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_bits (io_out_bits)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Reference predictor
  int m_sample, m_step, m_half, m_hi;

  // Inputs only change 1 time unit after a posedge, so a valid&ready pair seen at
  // a negedge is a handshake at the following posedge.
  always @(negedge clock) begin
    if (reset_n && io_out_valid && io_out_ready) got_q.push_back(io_out_bits);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic model_reset();
    m_sample = 0;
    m_step   = 127;
    m_half   = 0;
    m_hi     = 0;
  endtask

  task automatic model_pcm(input int pcm);
    int diff, mag, s, m, f, p, d, mul, nib;
    diff = pcm - m_sample;
    s    = (diff < 0) ? 1 : 0;
    mag  = s ? -diff : diff;
    m    = (4 * mag) / m_step;
    if (m > 7) m = 7;
    f = 2 * m + 1;
    if (s != 0) f = -f;
    p = m_step * f;
    d = (p >= 0) ? p / 8 : -((-p + 7) / 8);
    m_sample = m_sample + d;
    if (m_sample > 32767) m_sample = 32767;
    if (m_sample < -32768) m_sample = -32768;
    if (m <= 3) mul = 230;
    else if (m == 4) mul = 307;
    else if (m == 5) mul = 409;
    else if (m == 6) mul = 512;
    else mul = 614;
    m_step = (m_step * mul) / 256;
    if (m_step > 24576) m_step = 24576;
    if (m_step < 127) m_step = 127;
    nib = s * 8 + m;
    if (m_half == 0) begin
      m_hi   = nib;
      m_half = 1;
    end else begin
      exp_q.push_back(8'(m_hi * 16 + nib));
      m_half = 0;
    end
  endtask

  // Offer one sample and wait for acceptance; optionally jitter io_out_ready meanwhile.
  task automatic send(input int pcm, input bit jitter);
    int n;
    n = 0;
    io_in_valid = 1'b1;
    io_in_bits  = 16'(pcm);
    @(negedge clock);
    while (!io_in_ready && n < 200) begin
      @(posedge clock);
      #1;
      if (jitter) io_out_ready = ($urandom_range(0, 3) != 0);
      n++;
      @(negedge clock);
    end
    if (io_in_ready) model_pcm(pcm);
    else fail("send_accept");
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    io_start = 1'b1;
    @(posedge clock);
    #1;
    io_start = 1'b0;
    model_reset();
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (got_q.size() < n) fail("wait_bytes");
  endtask

  // Compare all bytes seen so far against the model's byte stream.
  task automatic drain(input string name);
    wait_bytes(exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check(name, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    end
    check({name, "_count"}, got_q.size() + exp_q.size(), 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_state(input string name);
    check({name, "_sample"}, int'(dut.sample_q), m_sample);
    check({name, "_step"}, int'(dut.step_q), m_step);
  endtask

  typedef struct {
    int         a;
    int         b;
    logic [7:0] byte_e;
    int         sample_e;
    int         step_e;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc, acc_cyc, val_cyc, accepts, bad, pcm, prev;
    logic [7:0] held;

    tbl[0] = '{a: 1000,   b: 1000,  byte_e: 8'h77, sample_e: 808,  step_e: 729};
    tbl[1] = '{a: -1000,  b: -1000, byte_e: 8'hFF, sample_e: -809, step_e: 729};
    tbl[2] = '{a: 0,      b: 0,     byte_e: 8'h08, sample_e: -1,   step_e: 127};
    tbl[3] = '{a: -32768, b: 100,   byte_e: 8'hF4, sample_e: 103,  step_e: 364};
    model_reset();

    // Reset state
    #12;
    check("reset_in_ready", int'(io_in_ready), 0);
    check("reset_out_valid", int'(io_out_valid), 0);
    check("reset_out_bits", int'(io_out_bits), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("idle_in_ready", int'(io_in_ready), 1);
    check_state("reset");

    // Known pairs, each starting from a cleared predictor
    foreach (tbl[i]) begin
      do_start();
      send(tbl[i].a, 1'b0);
      send(tbl[i].b, 1'b0);
      settle();
      wait_bytes(1);
      if (got_q.size() > 0) check($sformatf("tbl%0d_byte", i), int'(got_q[0]), int'(tbl[i].byte_e));
      check($sformatf("tbl%0d_sample", i), int'(dut.sample_q), tbl[i].sample_e);
      check($sformatf("tbl%0d_step", i), int'(dut.step_q), tbl[i].step_e);
      drain($sformatf("tbl%0d_model", i));
    end

    // Single zero sample from cleared state: step clamps back up to 127
    do_start();
    send(0, 1'b0);
    settle();
    check("zero_sample", int'(dut.sample_q), 15);
    check("zero_step", int'(dut.step_q), 127);

    // First-byte latency with io_in_valid held, then 20 cycles of backpressure
    do_start();
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_bits   = 16'd500;
    cyc = 0; acc_cyc = -1; val_cyc = -1; accepts = 0;
    while (cyc < 60 && val_cyc < 0) begin
      @(negedge clock);
      if (io_in_valid && io_in_ready) begin
        accepts++;
        model_pcm(500);
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (io_out_valid) val_cyc = cyc;
      @(posedge clock);
      #1;
      if (accepts == 2) io_in_valid = 1'b0;
      cyc++;
    end
    if (val_cyc < 0) fail("first_byte");
    else check("first_byte_latency", val_cyc - acc_cyc, 10);
    check("accepts_before_byte", accepts, 2);
    held = io_out_bits;
    io_in_valid = 1'b1;
    io_in_bits  = 16'd900;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (io_out_bits !== held || io_out_valid !== 1'b1 || io_in_ready !== 1'b0) bad++;
    end
    check("backpressure_hold", bad, 0);
    @(posedge clock);
    #1;
    io_out_ready = 1'b1;
    send(900, 1'b0);
    send(-5, 1'b0);
    settle();
    drain("backpressure_bytes");
    check_state("backpressure");

    // io_start in S1 while the second nibble of a byte is being built
    do_start();
    send(1234, 1'b0);
    send(-777, 1'b0);
    @(posedge clock);
    #1;
    io_start = 1'b1;
    @(posedge clock);
    #1;
    io_start = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (15) @(posedge clock);
    #1;
    check("start_s1_no_byte", got_q.size(), 0);
    check("start_s1_out_valid", int'(io_out_valid), 0);
    check_state("start_s1");
    send(1000, 1'b0);
    send(1000, 1'b0);
    settle();
    wait_bytes(1);
    if (got_q.size() > 0) check("start_s1_fresh_byte", int'(got_q[0]), 8'h77);
    drain("start_s1_model");

    // Sample offered together with io_start is refused
    io_in_valid = 1'b1;
    io_in_bits  = 16'd4000;
    io_start    = 1'b1;
    @(negedge clock);
    check("start_blocks_ready", int'(io_in_ready), 0);
    @(posedge clock);
    #1;
    io_start    = 1'b0;
    io_in_valid = 1'b0;
    model_reset();
    settle();
    check_state("start_refuse");

    // io_start during OUT drops io_out_valid
    io_out_ready = 1'b0;
    send(3000, 1'b0);
    send(-3000, 1'b0);
    repeat (6) @(posedge clock);
    #1;
    check("out_before_start", int'(io_out_valid), 1);
    io_start = 1'b1;
    @(posedge clock);
    #1;
    io_start = 1'b0;
    @(negedge clock);
    check("out_after_start", int'(io_out_valid), 0);
    check("ready_after_start", int'(io_in_ready), 1);
    @(posedge clock);
    #1;
    io_out_ready = 1'b1;
    model_reset();
    exp_q.delete();
    got_q.delete();

    // Saturation: sample pins at 32767, then full-swing input drives step to its ceiling
    repeat (8) send(32767, 1'b0);
    settle();
    check("sat_sample_max", int'(dut.sample_q), 32767);
    for (int i = 0; i < 12; i++) send((i % 2 == 0) ? -32768 : 32767, 1'b0);
    settle();
    check("sat_step_max", int'(dut.step_q), 24576);
    check_state("sat");
    drain("sat_bytes");

    // Random PCM with random output backpressure
    do_start();
    prev = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) pcm = int'($urandom_range(0, 65535)) - 32768;
      else pcm = prev + int'($urandom_range(0, 2000)) - 1000;
      if (pcm > 32767) pcm = 32767;
      if (pcm < -32768) pcm = -32768;
      prev = pcm;
      send(pcm, 1'b1);
    end
    io_out_ready = 1'b1;
    settle();
    check_state("random");
    drain("random_byte");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
